// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I Memory stage: one request at a time,
// a programmable number of wait states, then RV32I byte/half/word access semantics.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [3:0]    be;
  logic [31:0]   wd_lanes;
  logic          f3_ok, misaligned, out_of_range, acc_err;
  logic          do_access, mem_we;

  // Access decode works on the latched request fields.
  always_comb begin
    idx          = addr_q[AW+1:2];
    rd_word      = mem[idx];
    rd_byte      = rd_word[8*addr_q[1:0] +: 8];
    rd_half      = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    out_of_range = ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
    f3_ok        = 1'b1;
    misaligned   = 1'b0;
    load_data    = '0;
    be           = '0;
    wd_lanes     = wdata_q;
    case (funct3_q)
      3'b000: begin
        load_data = {{24{rd_byte[7]}}, rd_byte};
        be        = 4'b0001 << addr_q[1:0];
        wd_lanes  = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        misaligned = addr_q[0];
        load_data  = {{16{rd_half[15]}}, rd_half};
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_lanes   = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        misaligned = |addr_q[1:0];
        load_data  = rd_word;
        be         = 4'b1111;
      end
      3'b100: begin
        f3_ok     = !we_q;
        load_data = {24'd0, rd_byte};
      end
      3'b101: begin
        f3_ok      = !we_q;
        misaligned = addr_q[0];
        load_data  = {16'd0, rd_half};
      end
      default: f3_ok = 1'b0;
    endcase
    acc_err   = out_of_range || misaligned || !f3_ok;
    do_access = (state_q == WAIT) && (cnt_q == 4'd0);
    // Gating with rst keeps a store caught by reset at its access edge from landing.
    mem_we    = do_access && we_q && !acc_err && rst;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = 4'(WAIT_CYCLES);
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || we_q) ? '0 : load_data;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Storage has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule
